// File: rtl/vram_sched_pkg.sv
// Shared slot numbering and grant layout for the VRAM slot scheduler.
package vram_sched_pkg;

    typedef logic [1:0] slot_t;

    localparam slot_t SLOT_SPR = 2'd0;
    localparam slot_t SLOT_FIX = 2'd1;
    localparam slot_t SLOT_CPU = 2'd2;
    localparam slot_t SLOT_REF = 2'd3;

    localparam int GNT_SPR = 0;
    localparam int GNT_FIX = 1;
    localparam int GNT_CPU = 2;
    localparam int GNT_REF = 3;

    localparam logic [3:0] GRANT_CPU_MASK = 4'b0100;
    localparam logic [3:0] GRANT_RESET    = 4'b0001;

    localparam int TICK_W = 4;

endpackage

// File: rtl/vram_slot_timer.sv
// Tick/slot counters with HRESYNC realignment; exposes next-state values so the
// owner can register its outputs in step with the counters.
module vram_slot_timer
    import vram_sched_pkg::*;
#(
    parameter int SLOT_LEN = 4
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  ce_i,
    input  logic  hresync_i,
    output slot_t slot_o,
    output logic  last_o,
    output logic  resync_o,
    output slot_t slot_d_o,
    output logic  start_d_o,
    output logic  last_d_o,
    output logic  slot_start_o
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(SLOT_LEN - 1);

    logic [TICK_W-1:0] tick_q, tick_d;
    slot_t             slot_q, slot_d;
    logic              start_q, start_d;
    logic              resync;

    always_comb begin
        tick_d  = tick_q;
        slot_d  = slot_q;
        start_d = start_q;
        // Already at the start of a round: realigning would only repeat the pulse.
        resync  = hresync_i && !(slot_q == SLOT_SPR && tick_q == '0);
        if (ce_i) begin
            if (resync) begin
                tick_d  = '0;
                slot_d  = SLOT_SPR;
                start_d = 1'b1;
            end else if (tick_q == LAST) begin
                tick_d  = '0;
                slot_d  = slot_q + 2'd1;
                start_d = 1'b1;
            end else begin
                tick_d  = tick_q + 4'd1;
                start_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_q  <= '0;
            slot_q  <= SLOT_SPR;
            start_q <= 1'b1;
        end else begin
            tick_q  <= tick_d;
            slot_q  <= slot_d;
            start_q <= start_d;
        end
    end

    assign slot_o       = slot_q;
    assign last_o       = (tick_q == LAST);
    assign resync_o     = ce_i && resync;
    assign slot_d_o     = slot_d;
    assign start_d_o    = start_d;
    assign last_d_o     = (tick_d == LAST);
    assign slot_start_o = start_q;

endmodule

// File: rtl/vram_slot_sched.sv
// Four-slot VRAM bus scheduler: request latch, slot-2 ownership and registered
// one-hot grant, aligned with the slot timer's counters.
module vram_slot_sched
    import vram_sched_pkg::*;
#(
    parameter int SLOT_LEN = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CE,
    input  logic       HRESYNC,
    input  logic       CPU_REQ,
    input  logic       CPU_WR,
    input  logic       PREFETCH_EN,
    output logic [3:0] GRANT,
    output logic       SLOT_START,
    output logic       CPU_SEL,
    output logic       BUS_WE,
    output logic       CPU_PENDING,
    output logic       CPU_ACK
);

    slot_t      cur_slot, next_slot;
    logic       cur_last, next_last, next_start, resync;
    logic [3:0] slot_onehot_d;

    logic [3:0] grant_q, grant_d;
    logic       cpu_sel_q, cpu_sel_d;
    logic       bus_we_q, bus_we_d;
    logic       pend_q, pend_d;
    logic       wr_q, wr_d;
    logic       ack_q, ack_d;

    vram_slot_timer #(.SLOT_LEN(SLOT_LEN)) u_timer (
        .clk_i        (CLK),
        .rst_i        (RESET),
        .ce_i         (CE),
        .hresync_i    (HRESYNC),
        .slot_o       (cur_slot),
        .last_o       (cur_last),
        .resync_o     (resync),
        .slot_d_o     (next_slot),
        .start_d_o    (next_start),
        .last_d_o     (next_last),
        .slot_start_o (SLOT_START)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
        assign slot_onehot_d[gi] = (next_slot == slot_t'(gi));
    end

    always_comb begin
        grant_d   = grant_q;
        cpu_sel_d = cpu_sel_q;
        bus_we_d  = bus_we_q;
        pend_d    = pend_q;
        wr_d      = wr_q;
        ack_d     = ack_q;
        if (CE) begin
            // Completion needs the full slot; a realign on the last tick aborts it.
            ack_d = cpu_sel_q && (cur_slot == SLOT_CPU) && cur_last && !resync;
            if (ack_d) begin
                pend_d = 1'b0;
            end else if (CPU_REQ && !pend_q) begin
                pend_d = 1'b1;
                wr_d   = CPU_WR;
            end

            cpu_sel_d = 1'b0;
            grant_d   = slot_onehot_d;
            if (next_slot == SLOT_CPU) begin
                if (next_start) begin
                    cpu_sel_d = pend_d;
                    grant_d   = (pend_d || PREFETCH_EN) ? GRANT_CPU_MASK : 4'b0000;
                end else begin
                    cpu_sel_d = cpu_sel_q;
                    grant_d   = grant_q;
                end
            end
            bus_we_d = cpu_sel_d && next_last && wr_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            grant_q   <= GRANT_RESET;
            cpu_sel_q <= 1'b0;
            bus_we_q  <= 1'b0;
            pend_q    <= 1'b0;
            wr_q      <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            grant_q   <= grant_d;
            cpu_sel_q <= cpu_sel_d;
            bus_we_q  <= bus_we_d;
            pend_q    <= pend_d;
            wr_q      <= wr_d;
            ack_q     <= ack_d;
        end
    end

    assign GRANT       = grant_q;
    assign CPU_SEL     = cpu_sel_q;
    assign BUS_WE      = bus_we_q;
    assign CPU_PENDING = pend_q;
    assign CPU_ACK     = ack_q;

endmodule

// File: tb/tb_vram_slot_sched.sv
// Bench for vram_slot_sched: slot sequencing checks plus a scoreboard of
// expected BUS_WE / CPU_ACK tick numbers.
module tb_vram_slot_sched;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       CE = 1'b1;
    logic       HRESYNC = 1'b0;
    logic       CPU_REQ = 1'b0;
    logic       CPU_WR = 1'b0;
    logic       PREFETCH_EN = 1'b1;
    logic [3:0] GRANT;
    logic       SLOT_START, CPU_SEL, BUS_WE, CPU_PENDING, CPU_ACK;

    int   n_checks = 0;
    int   n_errors = 0;
    int   ck = 0;      // CE ticks since reset release
    int   base = 0;    // ck value of the most recent round start
    logic ce_edge = 1'b0;
    int   ackq[$];
    int   weq[$];

    always #5 CLK = ~CLK;

    vram_slot_sched #(.SLOT_LEN(4)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .CE          (CE),
        .HRESYNC     (HRESYNC),
        .CPU_REQ     (CPU_REQ),
        .CPU_WR      (CPU_WR),
        .PREFETCH_EN (PREFETCH_EN),
        .GRANT       (GRANT),
        .SLOT_START  (SLOT_START),
        .CPU_SEL     (CPU_SEL),
        .BUS_WE      (BUS_WE),
        .CPU_PENDING (CPU_PENDING),
        .CPU_ACK     (CPU_ACK)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (tick %0d)", tag, act, exp, ck);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_to(input int t);
        int guard = 0;
        while (ck < t && guard < 1000) begin
            step(1);
            guard++;
        end
        check("wait_to", ck, t);
    endtask

    // Plain rotation with no CPU ownership and prefetch enabled.
    task automatic chk_pos();
        int pos = ck - base;
        check("grant", int'(GRANT), 1 << ((pos / 4) % 4));
        check("slot_start", int'(SLOT_START), int'(pos % 4 == 0));
    endtask

    task automatic sparse_tick();
        CE = 1'b1;
        step(1);
        chk_pos();
        CE = 1'b0;
        step(1);
        chk_pos();
        step(1);
        chk_pos();
    endtask

    always @(posedge CLK) begin
        ce_edge <= RESET | CE;
        if (RESET)   ck <= 0;
        else if (CE) ck <= ck + 1;
    end

    always @(negedge CLK) begin
        check("onehot", int'($countones(GRANT) <= 1), 1);
        if (ce_edge) begin
            if (CPU_ACK) begin
                if (ackq.size() == 0) check("ack_spurious", ck, -1);
                else check("ack_time", ck, ackq.pop_front());
                $display("ack observed at tick %0d", ck);
            end
            if (BUS_WE) begin
                if (weq.size() == 0) check("we_spurious", ck, -1);
                else check("we_time", ck, weq.pop_front());
                $display("bus_we observed at tick %0d", ck);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tick %0d", ck);
        $fatal(1, "watchdog");
    end

    initial begin
        step(2);
        check("rst_grant", int'(GRANT), 1);
        check("rst_start", int'(SLOT_START), 1);
        check("rst_sel", int'(CPU_SEL), 0);
        check("rst_we", int'(BUS_WE), 0);
        check("rst_pend", int'(CPU_PENDING), 0);
        check("rst_ack", int'(CPU_ACK), 0);
        RESET = 1'b0;

        // Free-running rotation.
        while (ck < 32) begin
            chk_pos();
            step(1);
        end

        // Write request in slot 1 is served by the next slot 2.
        wait_to(36);
        CPU_REQ = 1'b1;
        CPU_WR  = 1'b1;
        weq.push_back(43);
        ackq.push_back(44);
        $display("req wr=1 at tick %0d", ck);
        step(1);
        CPU_REQ = 1'b0;
        check("t2_pend", int'(CPU_PENDING), 1);
        wait_to(40);
        check("t2_sel", int'(CPU_SEL), 1);
        check("t2_grant", int'(GRANT), 4);
        wait_to(44);
        check("t2_pend_clr", int'(CPU_PENDING), 0);

        // Request on the first tick of slot 2 waits a full round.
        wait_to(56);
        check("t3_sel_pf", int'(CPU_SEL), 0);
        check("t3_grant_pf", int'(GRANT), 4);
        CPU_REQ = 1'b1;
        CPU_WR  = 1'b0;
        ackq.push_back(76);
        $display("req wr=0 at tick %0d", ck);
        step(1);
        CPU_REQ = 1'b0;
        check("t3_pend", int'(CPU_PENDING), 1);
        check("t3_sel_hold", int'(CPU_SEL), 0);
        wait_to(72);
        check("t3_sel", int'(CPU_SEL), 1);

        // HRESYNC on the third tick of a CPU slot aborts and retries.
        wait_to(80);
        CPU_REQ = 1'b1;
        CPU_WR  = 1'b1;
        $display("req wr=1 at tick %0d", ck);
        step(1);
        CPU_REQ = 1'b0;
        wait_to(90);
        check("t4_sel", int'(CPU_SEL), 1);
        HRESYNC = 1'b1;
        step(1);
        HRESYNC = 1'b0;
        base = ck;
        weq.push_back(base + 11);
        ackq.push_back(base + 12);
        $display("hresync abort, new round at tick %0d", ck);
        check("t4_grant", int'(GRANT), 1);
        check("t4_start", int'(SLOT_START), 1);
        check("t4_pend", int'(CPU_PENDING), 1);
        check("t4_sel", int'(CPU_SEL), 0);

        // HRESYNC on tick 0 of slot 0 changes nothing.
        wait_to(base + 16);
        check("noop_start0", int'(SLOT_START), 1);
        HRESYNC = 1'b1;
        step(1);
        HRESYNC = 1'b0;
        check("noop_start1", int'(SLOT_START), 0);
        check("noop_grant", int'(GRANT), 1);

        // Prefetch disabled, nothing pending: idle slot 2.
        PREFETCH_EN = 1'b0;
        wait_to(base + 24);
        for (int i = 0; i < 4; i++) begin
            check("t5_idle", int'(GRANT), 0);
            check("t5_sel", int'(CPU_SEL), 0);
            step(1);
        end
        check("t5_ref", int'(GRANT), 8);
        PREFETCH_EN = 1'b1;

        // CE one-in-three, then reset in the middle of a CPU slot.
        wait_to(base + 32);
        check("t6_pend0", int'(CPU_PENDING), 0);
        CPU_REQ = 1'b1;
        CPU_WR  = 1'b1;
        $display("req wr=1 at tick %0d (sparse CE)", ck);
        sparse_tick();
        CPU_REQ = 1'b0;
        while (ck < base + 42) sparse_tick();
        check("t6_sel", int'(CPU_SEL), 1);
        check("t6_pend", int'(CPU_PENDING), 1);
        RESET = 1'b1;
        step(1);
        RESET = 1'b0;
        base = 0;
        $display("reset mid cpu slot");
        check("t6_rst_grant", int'(GRANT), 1);
        check("t6_rst_pend", int'(CPU_PENDING), 0);
        check("t6_rst_start", int'(SLOT_START), 1);
        check("t6_rst_sel", int'(CPU_SEL), 0);
        CE = 1'b1;
        while (ck < 20) begin
            chk_pos();
            step(1);
        end
        check("t6_pend_end", int'(CPU_PENDING), 0);
        check("ack_left", ackq.size(), 0);
        check("we_left", weq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
